thermo_rank_sel: RTL and testbench

- Streaming, pipelined successor to the four-input "second largest" thermometer selector.
- Accepts N_CH thermometer-coded channels per transaction and returns the value at a runtime-selectable rank (0 = largest ... N_CH-1 = smallest) as a binary count.
- Detects malformed ("bubbled") thermometer codes and keeps a saturating error counter.
- Sits between thermometer-output sensor/ADC front-ends and binary consumers, using valid/ready on both sides.

---
 rtl/thermo_pkg.sv | 41 ++++
 rtl/thermo_sanitize.sv | 25 ++
 rtl/thermo_rank_sel.sv | 143 ++++++++++++++
 tb/tb_thermo_rank_sel.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thermo_pkg.sv
// Shared definitions for the thermometer rank selector: width helpers,
// default parameter values and the thermometer-to-binary conversion.
package thermo_pkg;

    // Ceiling log2, usable in parameter declarations.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

    localparam int DEF_N_CH     = 4;
    localparam int DEF_THERMO_W = 15;
    localparam int DEF_ERR_W    = 8;
    localparam int DEF_VAL_W    = clog2(DEF_THERMO_W + 1);
    localparam int DEF_RANK_W   = clog2(DEF_N_CH);

    // Number of consecutive ones starting at bit 0, looking at the low
    // 'width' bits only (width must not exceed 32).
    function automatic int thermo_to_bin(input logic [31:0] code, input int width);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if ((i < width) && run && code[i]) begin
                n = n + 1;
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/thermo_sanitize.sv
// Per-channel thermometer sanitizer: converts one code to its binary run
// length and flags codes that are not a clean run of ones from bit 0.
module thermo_sanitize
    import thermo_pkg::*;
#(
    parameter int THERMO_W = DEF_THERMO_W,
    parameter int VAL_W    = clog2(THERMO_W + 1)
) (
    input  logic [THERMO_W-1:0] code,
    output logic [VAL_W-1:0]    value,
    output logic                bubble
);

    int                  cnt_s;
    logic [THERMO_W-1:0] clean_s;

    // Run length from bit 0, and the clean code that run length implies.
    always_comb begin
        cnt_s   = thermo_to_bin(32'(code), THERMO_W);
        clean_s = ~({THERMO_W{1'b1}} << cnt_s);
        value   = VAL_W'(cnt_s);
        bubble  = (code != clean_s);
    end

endmodule

// File: rtl/thermo_rank_sel.sv
// Two-stage streaming rank selector over N_CH thermometer channels.
// Stage 1 sanitizes and registers the channel values; stage 2 picks the
// value at the requested rank and holds it until the consumer takes it.
module thermo_rank_sel
    import thermo_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int THERMO_W = DEF_THERMO_W,
    parameter int VAL_W    = clog2(THERMO_W + 1),
    parameter int RANK_W   = clog2(N_CH),
    parameter int ERR_W    = DEF_ERR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_CH*THERMO_W-1:0] in_data,
    input  logic [RANK_W-1:0]        in_rank,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [VAL_W-1:0]         out_value,
    output logic                     out_bubble,
    input  logic                     err_clr,
    output logic [ERR_W-1:0]         err_count
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [VAL_W-1:0]  ch_val_s [N_CH];
    logic [N_CH-1:0]   ch_bub_s;
    logic              bubble_any_s;
    logic [RANK_W-1:0] rank_clamp_s;
    logic              in_fire_s;
    logic              s1_adv_s;
    logic [VAL_W-1:0]  sel_s;

    logic              s1_valid_r;
    logic [VAL_W-1:0]  s1_val_r [N_CH];
    logic              s1_bubble_r;
    logic [RANK_W-1:0] s1_rank_r;

    for (genvar c = 0; c < N_CH; c++) begin : g_san
        thermo_sanitize #(
            .THERMO_W (THERMO_W),
            .VAL_W    (VAL_W)
        ) u_san (
            .code   (in_data[c*THERMO_W +: THERMO_W]),
            .value  (ch_val_s[c]),
            .bubble (ch_bub_s[c])
        );
    end

    // Handshake: stage 1 moves on when stage 2 is empty or emptying; the
    // input side only sees registered state and out_ready, never in_valid.
    always_comb begin
        s1_adv_s     = s1_valid_r && (!out_valid || out_ready);
        in_ready     = !s1_valid_r || s1_adv_s;
        in_fire_s    = in_valid && in_ready;
        bubble_any_s = |ch_bub_s;
        if (int'(in_rank) > (N_CH - 1)) begin
            rank_clamp_s = RANK_W'(N_CH - 1);
        end else begin
            rank_clamp_s = in_rank;
        end
    end

    // Rank select: thermometer bit p is set when at least rank+1 channels
    // exceed p; its population count is the rank-th largest value.
    always_comb begin : p_select
        int gt_cnt;
        gt_cnt = 0;
        sel_s  = '0;
        for (int p = 0; p < THERMO_W; p++) begin
            gt_cnt = 0;
            for (int c = 0; c < N_CH; c++) begin
                if (int'(s1_val_r[c]) > p) begin
                    gt_cnt = gt_cnt + 1;
                end else begin
                    gt_cnt = gt_cnt;
                end
            end
            if (gt_cnt >= (int'(s1_rank_r) + 1)) begin
                sel_s = sel_s + VAL_W'(1);
            end else begin
                sel_s = sel_s;
            end
        end
    end

    // Stage 1: capture sanitized values, bubble summary and clamped rank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_bubble_r <= 1'b0;
            s1_rank_r   <= '0;
            for (int c = 0; c < N_CH; c++) begin
                s1_val_r[c] <= '0;
            end
        end else if (in_fire_s) begin
            s1_valid_r  <= 1'b1;
            s1_bubble_r <= bubble_any_s;
            s1_rank_r   <= rank_clamp_s;
            for (int c = 0; c < N_CH; c++) begin
                s1_val_r[c] <= ch_val_s[c];
            end
        end else if (s1_adv_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: registered result, frozen while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_value  <= '0;
            out_bubble <= 1'b0;
        end else if (s1_adv_s) begin
            out_valid  <= 1'b1;
            out_value  <= sel_s;
            out_bubble <= s1_bubble_r;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Saturating count of accepted bubbled transactions; clear has priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (in_fire_s && bubble_any_s && (err_count != ERR_MAX)) begin
            err_count <= err_count + ERR_W'(1);
        end else begin
            err_count <= err_count;
        end
    end

endmodule

// File: tb/tb_thermo_rank_sel.sv
// Self-checking bench for thermo_rank_sel: directed cases from the feature
// list plus a randomized stream against a sort-based reference model.
module tb_thermo_rank_sel;
    import thermo_pkg::*;

    localparam int NC = 4;
    localparam int TW = 15;
    localparam int DW = NC * TW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [1:0]    in_rank;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_value;
    logic          out_bubble;
    logic          err_clr;
    logic [7:0]    err_count;

    int checks   = 0;
    int failures = 0;

    thermo_rank_sel dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_rank    (in_rank),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_value  (out_value),
        .out_bubble (out_bubble),
        .err_clr    (err_clr),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Clean thermometer codes for channel values a..d (channel 0 = a).
    function automatic logic [DW-1:0] mk(input int a, input int b, input int c, input int d);
        logic [DW-1:0] r;
        int v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        r = '0;
        for (int k = 0; k < NC; k++) begin
            r[k*TW +: TW] = TW'((32'd1 << v[k]) - 32'd1);
        end
        return r;
    endfunction

    // Reference: sanitize each channel, sort descending, index by rank.
    function automatic void model(input logic [DW-1:0] d, input logic [1:0] r,
                                  output logic [3:0] ev, output logic eb);
        int vals[4];
        int tmp;
        logic [TW-1:0] code;
        eb = 1'b0;
        for (int k = 0; k < NC; k++) begin
            code    = d[k*TW +: TW];
            vals[k] = thermo_to_bin(32'(code), TW);
            if (code != TW'((32'd1 << vals[k]) - 32'd1)) eb = 1'b1;
        end
        for (int i = 0; i < NC; i++) begin
            for (int j = 0; j < NC - 1 - i; j++) begin
                if (vals[j] < vals[j+1]) begin
                    tmp = vals[j]; vals[j] = vals[j+1]; vals[j+1] = tmp;
                end
            end
        end
        ev = 4'(vals[int'(r)]);
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int k = 0; k < NC; k++) begin
            if ($urandom_range(0, 4) == 0) r[k*TW +: TW] = TW'($urandom);
            else r[k*TW +: TW] = TW'((32'd1 << $urandom_range(0, TW)) - 32'd1);
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction with latency and result checks.
    task automatic run_one(input logic [DW-1:0] d, input logic [1:0] r,
                           input logic [3:0] ev, input logic eb, input string nm);
        in_data = d; in_rank = r; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL %s in_ready got=%b exp=1", nm, in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL %s early_valid got=%b exp=0", nm, out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL %s latency got=%b exp=1", nm, out_valid); end
        checks++;
        if (out_value !== ev) begin failures++; $display("FAIL %s value got=%0d exp=%0d", nm, out_value, ev); end
        checks++;
        if (out_bubble !== eb) begin failures++; $display("FAIL %s bubble got=%b exp=%b", nm, out_bubble, eb); end
        tick();
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || out_value !== 4'd0 || out_bubble !== 1'b0) begin
            failures++; $display("FAIL reset_out got=%b/%0d/%b exp=0/0/0", out_valid, out_value, out_bubble);
        end
        checks++;
        if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d exp=0", err_count); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single();
        run_one(mk(4, 6, 5, 4), 2'd1, 4'd5, 1'b0, "single_a");
        run_one(mk(15, 7, 5, 4), 2'd1, 4'd7, 1'b0, "single_b");
        run_one(mk(0, 7, 8, 0), 2'd1, 4'd7, 1'b0, "single_c");
    endtask

    task automatic test_rank_sweep();
        logic [3:0] exp_v [4];
        exp_v[0] = 4'd15; exp_v[1] = 4'd14; exp_v[2] = 4'd13; exp_v[3] = 4'd12;
        for (int r = 0; r < 4; r++) begin
            run_one(mk(12, 14, 15, 13), 2'(r), exp_v[r], 1'b0, "rank_sweep");
        end
    endtask

    task automatic test_edges();
        run_one(mk(0, 0, 0, 0), 2'd1, 4'd0, 1'b0, "all_zero");
        run_one(mk(15, 15, 15, 15), 2'd2, 4'd15, 1'b0, "all_ones");
        run_one(mk(15, 15, 0, 0), 2'd1, 4'd15, 1'b0, "tie_hi");
        run_one(mk(15, 15, 0, 0), 2'd2, 4'd0, 1'b0, "tie_lo");
        run_one(mk(11, 11, 11, 0), 2'd2, 4'd11, 1'b0, "tie_three");
        run_one(mk(6, 6, 7, 7), 2'd1, 4'd7, 1'b0, "tie_pairs");
    endtask

    task automatic test_bubble();
        logic [DW-1:0] d;
        d = mk(0, 6, 5, 4);
        d[TW-1:0] = 15'b000000000111011;
        checks++;
        if (err_count !== 8'd0) begin failures++; $display("FAIL bubble_err_before got=%0d exp=0", err_count); end
        run_one(d, 2'd1, 4'd5, 1'b1, "bubble");
        checks++;
        if (err_count !== 8'd1) begin failures++; $display("FAIL bubble_err_after got=%0d exp=1", err_count); end
    endtask

    task automatic test_saturate();
        logic [DW-1:0] d;
        int acc;
        int cyc;
        d = mk(3, 2, 1, 0);
        d[TW +: TW] = 15'b000000000000101;
        acc = 0; cyc = 0;
        out_ready = 1'b1; in_rank = 2'd0; in_data = d;
        while (acc < 300 && cyc < 400) begin
            in_valid = 1'b1;
            #1;
            if (in_ready) acc++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (acc != 300) begin failures++; $display("FAIL saturate_accepted got=%0d exp=300", acc); end
        checks++;
        if (err_count !== 8'd255) begin failures++; $display("FAIL saturate_err got=%0d exp=255", err_count); end
        tick(); tick(); tick();
    endtask

    task automatic test_err_clr();
        logic [DW-1:0] d;
        d = mk(5, 5, 5, 5);
        d[2*TW +: TW] = 15'b100000000000011;
        in_data = d; in_rank = 2'd0; out_ready = 1'b1;
        in_valid = 1'b1; err_clr = 1'b1;
        tick();
        err_clr = 1'b0; in_valid = 1'b0;
        checks++;
        if (err_count !== 8'd0) begin failures++; $display("FAIL clr_wins got=%0d exp=0", err_count); end
        tick(); tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (err_count !== 8'd1) begin failures++; $display("FAIL clr_recount got=%0d exp=1", err_count); end
        tick(); tick();
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] d [4];
        logic [3:0] exp_v [4];
        int k;
        d[0] = mk(1, 2, 3, 4);   exp_v[0] = 4'd4;
        d[1] = mk(9, 8, 7, 6);   exp_v[1] = 4'd9;
        d[2] = mk(3, 3, 3, 3);   exp_v[2] = 4'd3;
        d[3] = mk(10, 0, 0, 0);  exp_v[3] = 4'd10;
        k = 0;
        out_ready = 1'b0; in_rank = 2'd0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            in_data = d[k]; in_valid = 1'b1;
            #1;
            checks++;
            if (in_ready !== (cyc < 2)) begin
                failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=%b", cyc, in_ready, (cyc < 2));
            end
            if (cyc >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_value !== exp_v[0]) begin
                    failures++; $display("FAIL bp_stable cyc=%0d got=%b/%0d exp=1/%0d", cyc, out_valid, out_value, exp_v[0]);
                end
            end
            if (in_ready) k++;
            tick();
        end
        checks++;
        if (k != 2) begin failures++; $display("FAIL bp_accepted got=%0d exp=2", k); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (k < 4) begin in_data = d[k]; in_valid = 1'b1; end
            else in_valid = 1'b0;
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_value !== exp_v[cyc]) begin
                failures++; $display("FAIL bp_order idx=%0d got=%b/%0d exp=1/%0d", cyc, out_valid, out_value, exp_v[cyc]);
            end
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_random();
        logic [3:0] exp_q [$];
        logic       bub_q [$];
        logic [3:0] ev;
        logic       eb;
        logic [3:0] pv;
        logic       pb;
        logic       prev_stall;
        logic       pend;
        logic       fire;
        int         err_m;
        int         drain;
        err_m = int'(err_count);
        prev_stall = 1'b0; pend = 1'b0; pv = '0; pb = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = rand_data();
                in_rank  = 2'($urandom);
            end
            out_ready = ($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            #1;
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_value !== pv || out_bubble !== pb) begin
                    failures++; $display("FAIL rnd_stable got=%b/%0d/%b exp=1/%0d/%b", out_valid, out_value, out_bubble, pv, pb);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rnd_spurious got=%0d exp=none", out_value);
                end else begin
                    ev = exp_q.pop_front(); eb = bub_q.pop_front();
                    if (out_value !== ev || out_bubble !== eb) begin
                        failures++; $display("FAIL rnd_result got=%0d/%b exp=%0d/%b", out_value, out_bubble, ev, eb);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            pv = out_value; pb = out_bubble;
            fire = in_valid && in_ready;
            pend = in_valid && !in_ready;
            if (fire) begin
                model(in_data, in_rank, ev, eb);
                exp_q.push_back(ev); bub_q.push_back(eb);
            end
            if (err_clr) err_m = 0;
            else if (fire && eb && err_m < 255) err_m++;
            tick();
            checks++;
            if (err_count !== 8'(err_m)) begin failures++; $display("FAIL rnd_err got=%0d exp=%0d", err_count, err_m); end
        end
        in_valid = 1'b0; err_clr = 1'b0; out_ready = 1'b1;
        drain = 0;
        while (exp_q.size() != 0 && drain < 10) begin
            #1;
            if (out_valid) begin
                checks++;
                ev = exp_q.pop_front(); eb = bub_q.pop_front();
                if (out_value !== ev || out_bubble !== eb) begin
                    failures++; $display("FAIL rnd_drain got=%0d/%b exp=%0d/%b", out_value, out_bubble, ev, eb);
                end
            end
            tick();
            drain++;
        end
        checks++;
        if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_lost got=%0d exp=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] d;
        d = mk(2, 2, 2, 2);
        d[3*TW +: TW] = 15'b010000000000000;
        out_ready = 1'b0; in_rank = 2'd0; in_data = d; in_valid = 1'b1;
        tick(); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_value !== 4'd0 || out_bubble !== 1'b0) begin
            failures++; $display("FAIL midrst_out got=%b/%0d/%b exp=0/0/0", out_valid, out_value, out_bubble);
        end
        checks++;
        if (err_count !== 8'd0) begin failures++; $display("FAIL midrst_err got=%0d exp=0", err_count); end
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale cyc=%0d got=%b exp=0", i, out_valid); end
            tick();
        end
        run_one(mk(4, 6, 5, 4), 2'd1, 4'd5, 1'b0, "midrst_next");
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_rank = '0;
        out_ready = 1'b0; err_clr = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        test_reset();
        test_single();
        test_rank_sweep();
        test_edges();
        test_bubble();
        test_saturate();
        test_err_clr();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
